crt_fetch_addr_gen: RTL and testbench

- Parametrised successor to the legacy CRT address generator.
- Produces per-row display fetch requests for the CRT FIFO path, using a valid/ready burst handshake.
- Width, addressing granularity, wrap window and burst size are generic.
- Adds double-buffered (tear-free) start address page flip, a request state machine, underrun detection and a burst-granular cursor hit.
- Sits between CRT timing (row/frame pulses) and the memory arbiter request port.

---
 rtl/crt_fetch_addr_gen_pkg.sv | 28 ++
 rtl/crt_fetch_addr_gen_if.sv | 23 ++
 rtl/crt_fetch_addr_gen_page_flip.sv | 45 ++++
 rtl/crt_fetch_addr_gen.sv | 127 ++++++++++++
 tb/tb_crt_fetch_addr_gen.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crt_fetch_addr_gen_pkg.sv
// Shared types and helpers for the CRT fetch address generator.
package crt_pkg;

   typedef enum logic [1:0] {
      MODE_BYTE  = 2'd0,
      MODE_WORD  = 2'd1,
      MODE_DWORD = 2'd2,
      MODE_QWORD = 2'd3
   } mode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_e;

   // log2 of the unit size in bytes for a given display mode
   function automatic logic [1:0] unit_shift(input logic [1:0] mode);
      logic [1:0] sh;
      case (mode_e'(mode))
         MODE_BYTE:  sh = 2'd0;
         MODE_WORD:  sh = 2'd1;
         MODE_DWORD: sh = 2'd2;
         default:    sh = 2'd3;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/crt_fetch_addr_gen_if.sv
// Fetch request handshake between the address generator and the memory arbiter.
interface crt_fetch_addr_gen_if #(
   parameter int ADDR_W = 24
);
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_last;
   logic              req_ready;

   modport master (
      output req_valid,
      output req_addr,
      output req_last,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_last,
      output req_ready
   );
endinterface

// File: rtl/crt_fetch_addr_gen_page_flip.sv
// Double-buffered display start address: software writes land in a pending
// register and are only applied at frame_start, so a page flip never tears.
module crt_page_flip #(
   parameter int ADDR_W = 24
) (
   input  logic              t_crt_clk,
   input  logic              hreset_n,
   input  logic              frame_start,
   input  logic              start_wr,
   input  logic [ADDR_W-1:0] start_addr,
   output logic [ADDR_W-1:0] next_start,
   output logic              flip_pending,
   output logic              flip_done
);

   logic [ADDR_W-1:0] active_start;
   logic [ADDR_W-1:0] pending_start;

   // Start address the frame will use if frame_start fires this cycle
   always_comb begin
      next_start = flip_pending ? pending_start : active_start;
   end

   // Apply the old pending value first; a same-cycle write then re-arms the flip
   always_ff @(posedge t_crt_clk or negedge hreset_n) begin
      if (!hreset_n) begin
         active_start  <= '0;
         pending_start <= '0;
         flip_pending  <= 1'b0;
         flip_done     <= 1'b0;
      end else begin
         flip_done <= 1'b0;
         if (frame_start && flip_pending) begin
            active_start <= pending_start;
            flip_pending <= 1'b0;
            flip_done    <= 1'b1;
         end
         if (start_wr) begin
            pending_start <= start_addr;
            flip_pending  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/crt_fetch_addr_gen.sv
// Per-row display fetch request generator for the CRT FIFO path.
module crt_fetch_addr_gen
   import crt_pkg::*;
#(
   parameter int ADDR_W = 24,
   parameter int OFF_W  = 12,
   parameter int LEN_W  = 8,
   parameter int BURST  = 8
) (
   input  logic                 t_crt_clk,
   input  logic                 hreset_n,
   input  logic                 frame_start,
   input  logic                 row_start,
   input  logic                 row_end,
   input  logic                 split_pulse,
   input  logic [1:0]           mode,
   input  logic [ADDR_W-1:0]    start_addr,
   input  logic                 start_wr,
   input  logic [OFF_W-1:0]     offset,
   input  logic [ADDR_W-1:0]    wrap_mask,
   input  logic [LEN_W-1:0]     fetch_len,
   input  logic [ADDR_W-1:0]    cursor_loc,
   crt_fetch_addr_gen_if.master req,
   output logic                 cursor_hit,
   output logic                 flip_pending,
   output logic                 flip_done,
   output logic                 underrun
);

   state_e            state;
   logic [ADDR_W-1:0] row_base;
   logic [ADDR_W-1:0] fetch_ptr;
   logic [LEN_W-1:0]  burst_cnt;
   logic [ADDR_W-1:0] next_start;
   logic [ADDR_W-1:0] burst_step;
   logic [ADDR_W-1:0] pitch;
   logic [ADDR_W-1:0] base_next;
   logic [ADDR_W-1:0] ptr_next;
   logic [ADDR_W:0]   cur_ext;
   logic [ADDR_W:0]   lo_ext;
   logic [ADDR_W:0]   hi_ext;

   crt_page_flip #(
      .ADDR_W (ADDR_W)
   ) u_page_flip (
      .t_crt_clk    (t_crt_clk),
      .hreset_n     (hreset_n),
      .frame_start  (frame_start),
      .start_wr     (start_wr),
      .start_addr   (start_addr),
      .next_start   (next_start),
      .flip_pending (flip_pending),
      .flip_done    (flip_done)
   );

   // Mode-scaled burst step and row pitch, plus the row base after split/row_end
   always_comb begin
      burst_step = ADDR_W'(BURST) << unit_shift(mode);
      pitch      = ADDR_W'(offset) << ({1'b0, unit_shift(mode)} + 3'd1);
      ptr_next   = fetch_ptr + burst_step;
      if (split_pulse) begin
         base_next = '0;
      end else if (row_end) begin
         base_next = row_base + pitch;
      end else begin
         base_next = row_base;
      end
   end

   // Cursor hit within the masked space; the extra bit keeps the burst end from wrapping
   always_comb begin
      cur_ext    = {1'b0, cursor_loc & wrap_mask};
      lo_ext     = {1'b0, req.req_addr};
      hi_ext     = lo_ext + {1'b0, burst_step} - 1'b1;
      cursor_hit = req.req_valid && (cur_ext >= lo_ext) && (cur_ext <= hi_ext);
   end

   // Request state machine with registered valid/addr/last; frame_start overrides everything
   always_ff @(posedge t_crt_clk or negedge hreset_n) begin
      if (!hreset_n) begin
         state         <= IDLE;
         row_base      <= '0;
         fetch_ptr     <= '0;
         burst_cnt     <= '0;
         underrun      <= 1'b0;
         req.req_valid <= 1'b0;
         req.req_addr  <= '0;
         req.req_last  <= 1'b0;
      end else if (frame_start) begin
         row_base      <= next_start;
         underrun      <= 1'b0;
         state         <= IDLE;
         req.req_valid <= 1'b0;
         req.req_last  <= 1'b0;
      end else begin
         row_base <= base_next;
         if (row_start) begin
            if (state == FETCH) begin
               underrun <= 1'b1;
            end
            fetch_ptr    <= base_next;
            burst_cnt    <= fetch_len;
            req.req_addr <= base_next & wrap_mask;
            req.req_last <= (fetch_len == LEN_W'(1));
            if (fetch_len != '0) begin
               state         <= FETCH;
               req.req_valid <= 1'b1;
            end else begin
               state         <= IDLE;
               req.req_valid <= 1'b0;
            end
         end else if (state == FETCH && req.req_ready) begin
            if (req.req_last) begin
               state         <= IDLE;
               req.req_valid <= 1'b0;
               req.req_last  <= 1'b0;
            end else begin
               fetch_ptr    <= ptr_next;
               burst_cnt    <= burst_cnt - 1'b1;
               req.req_addr <= ptr_next & wrap_mask;
               req.req_last <= (burst_cnt == LEN_W'(2));
            end
         end
      end
   end

endmodule

// File: tb/tb_crt_fetch_addr_gen.sv
// Scoreboard testbench for crt_fetch_addr_gen: expected bursts are queued as
// rows are started and compared as the arbiter side accepts each request.
module tb_crt_fetch_addr_gen;

   localparam int ADDR_W = 24;
   localparam int OFF_W  = 12;
   localparam int LEN_W  = 8;
   localparam int BURST  = 8;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic              last;
      logic              hit;
   } exp_t;

   logic              t_crt_clk;
   logic              hreset_n;
   logic              frame_start;
   logic              row_start;
   logic              row_end;
   logic              split_pulse;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] start_addr;
   logic              start_wr;
   logic [OFF_W-1:0]  offset;
   logic [ADDR_W-1:0] wrap_mask;
   logic [LEN_W-1:0]  fetch_len;
   logic [ADDR_W-1:0] cursor_loc;
   logic              cursor_hit;
   logic              flip_pending;
   logic              flip_done;
   logic              underrun;

   int   checks;
   int   errors;
   exp_t sb[$];

   crt_fetch_addr_gen_if #(.ADDR_W(ADDR_W)) req_if ();

   crt_fetch_addr_gen #(
      .ADDR_W (ADDR_W),
      .OFF_W  (OFF_W),
      .LEN_W  (LEN_W),
      .BURST  (BURST)
   ) dut (
      .t_crt_clk    (t_crt_clk),
      .hreset_n     (hreset_n),
      .frame_start  (frame_start),
      .row_start    (row_start),
      .row_end      (row_end),
      .split_pulse  (split_pulse),
      .mode         (mode),
      .start_addr   (start_addr),
      .start_wr     (start_wr),
      .offset       (offset),
      .wrap_mask    (wrap_mask),
      .fetch_len    (fetch_len),
      .cursor_loc   (cursor_loc),
      .req          (req_if.master),
      .cursor_hit   (cursor_hit),
      .flip_pending (flip_pending),
      .flip_done    (flip_done),
      .underrun     (underrun)
   );

   // 10 ns CRT clock
   initial begin
      t_crt_clk = 1'b0;
      forever #5 t_crt_clk = ~t_crt_clk;
   end

   // Absolute time limit so a stuck run still ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h required 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One-cycle pulses on the timing/strobe inputs, driven just after a rising edge
   task automatic applyStimulus(input logic fs, input logic rs, input logic re, input logic sp,
                                input logic sw, input logic [ADDR_W-1:0] sa);
      frame_start = fs;
      row_start   = rs;
      row_end     = re;
      split_pulse = sp;
      start_wr    = sw;
      start_addr  = sa;
      @(posedge t_crt_clk);
      #1;
      frame_start = 1'b0;
      row_start   = 1'b0;
      row_end     = 1'b0;
      split_pulse = 1'b0;
      start_wr    = 1'b0;
   endtask

   task automatic push_exp(input logic [ADDR_W-1:0] addr, input logic last, input logic hit);
      exp_t e;
      e.addr = addr;
      e.last = last;
      e.hit  = hit;
      sb.push_back(e);
   endtask

   // Wait for the scoreboard to empty, then confirm the generator went idle
   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge t_crt_clk);
         n++;
      end
      checkOutput({tag, "_drain_left"}, sb.size(), 0);
      sb.delete();
      @(negedge t_crt_clk);
      checkOutput({tag, "_idle_valid"}, {31'd0, req_if.req_valid}, 32'd0);
   endtask

   // Every accepted request is popped from the scoreboard and compared
   always @(negedge t_crt_clk) begin
      exp_t e;
      if (hreset_n && req_if.req_valid && req_if.req_ready) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_req", {8'd0, req_if.req_addr}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            checkOutput("req_addr", {8'd0, req_if.req_addr}, {8'd0, e.addr});
            checkOutput("req_last", {31'd0, req_if.req_last}, {31'd0, e.last});
            checkOutput("cursor_hit", {31'd0, cursor_hit}, {31'd0, e.hit});
         end
      end
   end

   initial begin
      checks           = 0;
      errors           = 0;
      hreset_n         = 1'b0;
      frame_start      = 1'b0;
      row_start        = 1'b0;
      row_end          = 1'b0;
      split_pulse      = 1'b0;
      start_wr         = 1'b0;
      start_addr       = '0;
      mode             = 2'd0;
      offset           = '0;
      wrap_mask        = 24'hFFFFFF;
      fetch_len        = '0;
      cursor_loc       = 24'h7FFF00;
      req_if.req_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge t_crt_clk);
      @(negedge t_crt_clk);
      checkOutput("rst_valid", {31'd0, req_if.req_valid}, 32'd0);
      checkOutput("rst_addr", {8'd0, req_if.req_addr}, 32'd0);
      checkOutput("rst_last", {31'd0, req_if.req_last}, 32'd0);
      checkOutput("rst_hit", {31'd0, cursor_hit}, 32'd0);
      checkOutput("rst_pending", {31'd0, flip_pending}, 32'd0);
      checkOutput("rst_done", {31'd0, flip_done}, 32'd0);
      checkOutput("rst_underrun", {31'd0, underrun}, 32'd0);
      @(posedge t_crt_clk);
      #1 hreset_n = 1'b1;
      @(posedge t_crt_clk);
      #1;

      // Page flip to 0x001000
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h001000);
      @(negedge t_crt_clk);
      checkOutput("flip_pending_set", {31'd0, flip_pending}, 32'd1);
      checkOutput("flip_done_early", {31'd0, flip_done}, 32'd0);
      @(posedge t_crt_clk);
      #1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      @(negedge t_crt_clk);
      checkOutput("flip_pending_clr", {31'd0, flip_pending}, 32'd0);
      checkOutput("flip_done_pulse", {31'd0, flip_done}, 32'd1);
      @(negedge t_crt_clk);
      checkOutput("flip_done_single", {31'd0, flip_done}, 32'd0);

      // Dword row of 3 bursts from the flipped base
      @(posedge t_crt_clk);
      #1;
      mode             = 2'd2;
      fetch_len        = 8'd3;
      req_if.req_ready = 1'b1;
      push_exp(24'h001000, 1'b0, 1'b0);
      push_exp(24'h001020, 1'b0, 1'b0);
      push_exp(24'h001040, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      wait_drain("row3", 20);

      // Row pitch: split to 0, then row_end steps of 0x140 in word mode
      @(posedge t_crt_clk);
      #1;
      mode      = 2'd1;
      offset    = 12'h050;
      fetch_len = 8'd1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      push_exp(24'h000140, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      wait_drain("pitch1", 10);
      @(posedge t_crt_clk);
      #1;
      push_exp(24'h000280, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      wait_drain("pitch2", 10);
      @(posedge t_crt_clk);
      #1;
      push_exp(24'h000000, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
      wait_drain("split", 10);

      // fetch_len of zero issues nothing
      @(posedge t_crt_clk);
      #1;
      fetch_len = 8'd0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      @(negedge t_crt_clk);
      checkOutput("len0_valid", {31'd0, req_if.req_valid}, 32'd0);

      // Backpressure hold, then row_start mid-fetch causes underrun and restarts
      @(posedge t_crt_clk);
      #1;
      mode             = 2'd2;
      fetch_len        = 8'd4;
      req_if.req_ready = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 5; i++) begin
         @(negedge t_crt_clk);
         checkOutput("hold_valid", {31'd0, req_if.req_valid}, 32'd1);
         checkOutput("hold_addr", {8'd0, req_if.req_addr}, 32'd0);
         checkOutput("hold_last", {31'd0, req_if.req_last}, 32'd0);
      end
      checkOutput("underrun_before", {31'd0, underrun}, 32'd0);
      @(posedge t_crt_clk);
      #1;
      push_exp(24'h000280, 1'b0, 1'b0);
      push_exp(24'h0002A0, 1'b0, 1'b0);
      push_exp(24'h0002C0, 1'b0, 1'b0);
      push_exp(24'h0002E0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      @(negedge t_crt_clk);
      checkOutput("underrun_set", {31'd0, underrun}, 32'd1);
      checkOutput("restart_addr", {8'd0, req_if.req_addr}, 32'h280);
      @(posedge t_crt_clk);
      #1 req_if.req_ready = 1'b1;
      wait_drain("restart", 20);
      checkOutput("underrun_sticky", {31'd0, underrun}, 32'd1);
      @(posedge t_crt_clk);
      #1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      @(negedge t_crt_clk);
      checkOutput("underrun_clr", {31'd0, underrun}, 32'd0);
      checkOutput("no_flip_done", {31'd0, flip_done}, 32'd0);

      // Wrap window: base 0xFFF0 under mask 0xFFFF, plus write in the frame_start cycle
      @(posedge t_crt_clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h00FFF0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h123456);
      @(negedge t_crt_clk);
      checkOutput("same_cycle_done", {31'd0, flip_done}, 32'd1);
      checkOutput("same_cycle_pending", {31'd0, flip_pending}, 32'd1);
      @(posedge t_crt_clk);
      #1;
      mode      = 2'd0;
      wrap_mask = 24'h00FFFF;
      fetch_len = 8'd3;
      push_exp(24'h00FFF0, 1'b0, 1'b0);
      push_exp(24'h00FFF8, 1'b0, 1'b0);
      push_exp(24'h000000, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      wait_drain("wrap", 20);

      // Cursor hit only on the burst containing 0x001024 (last write wins)
      @(posedge t_crt_clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h001000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      mode       = 2'd2;
      wrap_mask  = 24'hFFFFFF;
      cursor_loc = 24'h001024;
      push_exp(24'h001000, 1'b0, 1'b0);
      push_exp(24'h001020, 1'b0, 1'b1);
      push_exp(24'h001040, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      wait_drain("cursor", 20);
      checkOutput("cursor_idle", {31'd0, cursor_hit}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
